// File: rtl/note_select.sv
// note_select: debounces four keys, steps note (1..12) and octave (0..3), and issues held ld_note loads.
// Define NOTE_SEL_AUTOREPEAT_EN to add periodic repeat events while a key stays pressed.
module note_select #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LD_HOLD         = 1024,
    parameter int GAP_CYCLES      = 16,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_note_up,
    input  logic       key_note_dn,
    input  logic       key_oct_up,
    input  logic       key_oct_dn,
    output logic [3:0] note,
    output logic [1:0] octave,
    output logic       ld_note,
    output logic       busy
);
    localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMAX = LD_HOLD > GAP_CYCLES ? LD_HOLD : GAP_CYCLES;
    localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(LD_HOLD - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
`ifdef NOTE_SEL_AUTOREPEAT_EN
    localparam int RW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    note_q, note_d, note_w_q, note_w_d;
    logic [1:0]    octave_q, octave_d, oct_w_q, oct_w_d;
    logic          pending_q, pending_d, load, chg;
    logic [3:0]    keys, deb, rise, rep, ev;
    logic          n_up, n_dn, o_up, o_dn;

    // Key order: 0 note_up, 1 note_dn, 2 oct_up, 3 oct_dn
    assign keys = {key_oct_dn, key_oct_up, key_note_dn, key_note_up};

    for (genvar g = 0; g < 4; g++) begin : g_key
        logic          s1_q, s2_q, deb_q, tgl;
        logic [DW-1:0] cnt_q;
        assign tgl     = (s2_q != deb_q) && (cnt_q == DB_LAST);
        assign deb[g]  = deb_q;
        assign rise[g] = tgl & s2_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1_q  <= 1'b0;
                s2_q  <= 1'b0;
                deb_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                s1_q  <= keys[g];
                s2_q  <= s1_q;
                deb_q <= deb_q ^ tgl;
                cnt_q <= (s2_q == deb_q || tgl) ? '0 : cnt_q + 1'b1;
            end
        end
`ifdef NOTE_SEL_AUTOREPEAT_EN
        logic [RW-1:0] rcnt_q;
        assign rep[g] = deb_q && (rcnt_q == REP_LAST);
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) rcnt_q <= '0;
            else        rcnt_q <= (!deb_q || rep[g]) ? '0 : rcnt_q + 1'b1;
        end
`else
        assign rep[g] = 1'b0;
`endif
    end

    // A repeat is suppressed while the opposing key of its pair is also held
    assign ev   = rise | (rep & ~{deb[2], deb[3], deb[0], deb[1]});
    assign n_up = ev[0] & ~ev[1];
    assign n_dn = ev[1] & ~ev[0];
    assign o_up = ev[2] & ~ev[3];
    assign o_dn = ev[3] & ~ev[2];

    always_comb begin
        note_w_d  = n_up ? (note_w_q == 4'd12 ? 4'd1 : note_w_q + 4'd1)
                  : n_dn ? (note_w_q == 4'd1 ? 4'd12 : note_w_q - 4'd1) : note_w_q;
        oct_w_d   = (o_up && oct_w_q != 2'd3) ? oct_w_q + 2'd1
                  : (o_dn && oct_w_q != 2'd0) ? oct_w_q - 2'd1 : oct_w_q;
        chg       = (note_w_d != note_w_q) || (oct_w_d != oct_w_q);
        pending_d = chg | (pending_q & ~load);
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + 1'b1;
        note_d   = note_q;
        octave_d = octave_q;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (pending_q) begin
                    state_d  = HOLD;
                    load     = 1'b1;
                    note_d   = note_w_q;
                    octave_d = oct_w_q;
                end
            end
            HOLD: if (timer_q == HOLD_LAST) begin
                state_d = GAP;
                timer_d = '0;
            end
            GAP: if (timer_q == GAP_LAST) begin
                state_d = IDLE;
                timer_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // pending starts set so one load of the reset values follows every reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            note_q    <= 4'd1;
            octave_q  <= 2'd0;
            note_w_q  <= 4'd1;
            oct_w_q   <= 2'd0;
            pending_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            note_q    <= note_d;
            octave_q  <= octave_d;
            note_w_q  <= note_w_d;
            oct_w_q   <= oct_w_d;
            pending_q <= pending_d;
        end
    end

    assign note    = note_q;
    assign octave  = octave_q;
    assign ld_note = (state_q == HOLD);
    assign busy    = (state_q != IDLE) | pending_q;
endmodule

// File: tb/tb_note_select.sv
// tb_note_select: randomized and directed stimulus against a cycle-level behavioural model of note_select.
// Honours NOTE_SEL_AUTOREPEAT_EN for the repeat behaviour.
module tb_note_select;
    localparam int DB = 4, LH = 8, GP = 2, RP = 20;

    logic       clk = 1'b0, reset = 1'b0;
    logic [3:0] k = 4'd0;
    logic [3:0] note;
    logic [1:0] octave;
    logic       ld_note, busy;

    int n_cmp = 0, n_bad = 0, ld_rises = 0;
    bit prev_ld = 1'b0, el = 1'b0, eb = 1'b1;

    note_select #(.DEBOUNCE_CYCLES(DB), .LD_HOLD(LH), .GAP_CYCLES(GP), .REPEAT_CYCLES(RP)) dut (
        .clk(clk), .reset(reset),
        .key_note_up(k[0]), .key_note_dn(k[1]), .key_oct_up(k[2]), .key_oct_dn(k[3]),
        .note(note), .octave(octave), .ld_note(ld_note), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: synchronizer stages, debounced levels, sample windows, load schedule
    bit [3:0] m_s1, m_s2, m_deb;
    int m_win[4], m_fill[4], m_rise[4];
    int cur, m_start, m_free, m_nw, m_ow, m_note, m_oct;
    bit m_pend;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_deb = 0; cur = 0; m_start = -100; m_free = 0;
        m_nw = 1; m_ow = 0; m_note = 1; m_oct = 0; m_pend = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_win[i] = 0; m_fill[i] = 0; m_rise[i] = 0;
        end
    endtask

    task automatic model_step(output bit xl, output bit xb);
        bit [3:0] old, ev;
        bit load;
        int nw, ow;
        int mask = (1 << DB) - 1;
        old = m_deb; ev = 0; load = 0;
        if (m_pend && cur >= m_free) begin
            load = 1; m_start = cur; m_free = cur + LH + GP + 1; m_note = m_nw; m_oct = m_ow;
        end
        for (int i = 0; i < 4; i++) begin
            m_win[i] = ((m_win[i] << 1) | int'(m_s2[i])) & mask;
            m_fill[i]++;
`ifdef NOTE_SEL_AUTOREPEAT_EN
            if (old[i] && !old[i ^ 1] && cur > m_rise[i] && (cur - m_rise[i]) % RP == 0) ev[i] = 1;
`endif
            // debounced level flips once DB consecutive samples disagree with it
            if (m_fill[i] >= DB && m_win[i] == (old[i] ? 0 : mask)) begin
                m_deb[i] = !old[i]; m_fill[i] = 0;
                if (!old[i]) begin ev[i] = 1; m_rise[i] = cur; end
            end
        end
        nw = m_nw; ow = m_ow;
        if (ev[0] != ev[1]) nw = ev[0] ? nw % 12 + 1 : (nw + 10) % 12 + 1;
        if (ev[2] != ev[3]) ow = ev[2] ? (ow < 3 ? ow + 1 : 3) : (ow > 0 ? ow - 1 : 0);
        m_pend = (nw != m_nw || ow != m_ow) || (m_pend && !load);
        m_nw = nw; m_ow = ow;
        m_s2 = m_s1; m_s1 = k;
        xl = (cur >= m_start && cur < m_start + LH);
        xb = (cur >= m_start && cur < m_start + LH + GP) || m_pend;
        cur++;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (!reset) begin
            model_reset(); el = 1'b0; eb = 1'b1;
        end else model_step(el, eb);
        chk("note", int'(note), m_note);
        chk("octave", int'(octave), m_oct);
        chk("ld_note", int'(ld_note), int'(el));
        chk("busy", int'(busy), int'(eb));
        if (ld_note && !prev_ld) ld_rises++;
        prev_ld = ld_note;
    end

    task automatic press(input int idx, input int hi, input int lo);
        k[idx] = 1'b1;
        repeat (hi) @(negedge clk);
        k[idx] = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic wait_ld();
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = ld_note;
        end
        if (!ok) chk("ld_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 300 && !ok; i++) begin
            if (!busy) ok = 1;
            else @(negedge clk);
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int l0, len;
        repeat (3) @(negedge clk);
        chk("rst_ld", int'(ld_note), 0);
        chk("rst_busy", int'(busy), 1);
        reset = 1'b1;
        wait_ld();
        chk("boot_note", int'(note), 1);
        chk("boot_oct", int'(octave), 0);
        len = 0;
        while (ld_note && len < 40) begin
            len++;
            @(negedge clk);
        end
        chk("hold_len", len, LH);
        wait_idle();
        // bounce then steady hold: one event
        l0 = ld_rises;
        k[0] = 1'b1; @(negedge clk); k[0] = 1'b0; @(negedge clk);
        press(0, 11, 10);
        wait_idle();
        chk("bounce_loads", ld_rises - l0, 1);
        chk("bounce_note", int'(note), 2);
        l0 = ld_rises;
        press(1, 6, 8); press(1, 6, 8);
        wait_idle();
        chk("dn_wrap_note", int'(note), 12);
        press(0, 6, 8);
        wait_idle();
        chk("up_wrap_note", int'(note), 1);
        chk("wrap_loads", ld_rises - l0, 3);
        l0 = ld_rises;
        repeat (4) press(2, 6, 8);
        wait_idle();
        chk("oct_up_sat", int'(octave), 3);
        chk("oct_up_loads", ld_rises - l0, 3);
        l0 = ld_rises;
        repeat (4) press(3, 6, 8);
        wait_idle();
        chk("oct_dn_sat", int'(octave), 0);
        chk("oct_dn_loads", ld_rises - l0, 3);
        // opposing pair together: no change
        l0 = ld_rises;
        k = 4'b0011;
        repeat (30) @(negedge clk);
        k = 4'd0;
        repeat (10) @(negedge clk);
        wait_idle();
        chk("pair_loads", ld_rises - l0, 0);
        chk("pair_note", int'(note), 1);
        // events arriving during a load collapse into one follow-up load
        l0 = ld_rises;
        for (int c = 0; c < 16; c++) begin
            k[0] = (c < 4) || (c >= 8 && c < 12);
            k[2] = (c >= 2 && c < 6);
            @(negedge clk);
        end
        wait_idle();
        chk("coalesce_loads", ld_rises - l0, 2);
        chk("coalesce_note", int'(note), 3);
        chk("coalesce_oct", int'(octave), 1);
        l0 = ld_rises;
        press(0, 70, 10);
        wait_idle();
`ifdef NOTE_SEL_AUTOREPEAT_EN
        chk("hold70_loads", ld_rises - l0, 4);
        chk("hold70_note", int'(note), 7);
`else
        chk("hold70_loads", ld_rises - l0, 1);
        chk("hold70_note", int'(note), 4);
`endif
        // reset in the fourth HOLD cycle
        k[0] = 1'b1;
        wait_ld();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_ld", int'(ld_note), 0);
        chk("midrst_busy", int'(busy), 1);
        chk("midrst_note", int'(note), 1);
        k[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_ld();
        chk("reload_note", int'(note), 1);
        chk("reload_oct", int'(octave), 0);
        wait_idle();
        repeat (120) begin
            k = 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, 9)) @(negedge clk);
        end
        k = 4'd0;
        repeat (10) @(negedge clk);
        wait_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
